// File: rtl/sc_road_sequencer_pkg.sv
// Shared encodings for the road display sequencer:
// phase codes, row-mux select codes and row helpers.
package sc_road_sequencer_pkg;

  localparam int ROWS  = 7;
  localparam int SEL_W = 2;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COUNTDOWN = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_PAUSE     = 3'd3;
  localparam logic [2:0] ST_CRASH     = 3'd4;
  localparam logic [2:0] ST_GAMEOVER  = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    COUNTDOWN = ST_COUNTDOWN,
    PLAY      = ST_PLAY,
    PAUSE     = ST_PAUSE,
    CRASH     = ST_CRASH,
    GAMEOVER  = ST_GAMEOVER
  } state_e;

  localparam logic [SEL_W-1:0] SEL_ZERO  = 2'd0;
  localparam logic [SEL_W-1:0] SEL_ONES  = 2'd1;
  localparam logic [SEL_W-1:0] SEL_RAND  = 2'd2;
  localparam logic [SEL_W-1:0] SEL_SHIFT = 2'd3;

  // index 0 is row 1 (top of the road)
  typedef logic [ROWS-1:0][SEL_W-1:0] rows_t;

  function automatic rows_t fill_rows(
    input logic [SEL_W-1:0] code
  );
    rows_t r;
    for (int i = 0; i < ROWS; i++) begin
      r[i] = code;
    end
    return r;
  endfunction

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sc_road_sequencer_if.sv
// Pin bundle around the road sequencer: player/time-base
// inputs and the row-control outputs.
interface sc_road_sequencer_if
  import sc_road_sequencer_pkg::*;
#(
  parameter int SELECT_WIDTH = 2
);

  logic                    start_n;
  logic                    pause_n;
  logic                    tick;
  logic                    crash;
  logic [SELECT_WIDTH-1:0] sel [ROWS];
  logic                    load;
  logic [2:0]              state;
  logic [7:0]              score;

  modport master (
    output start_n, pause_n, tick, crash,
    input  sel, load, state, score
  );

  modport slave (
    input  start_n, pause_n, tick, crash,
    output sel, load, state, score
  );

endinterface

// File: rtl/sc_button_edge.sv
// Two-flop synchronizer for an active-low button
// followed by a falling-edge one-shot.
module sc_button_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  // released level is 1, so reset cannot fake a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= btn_n_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign press_o = prev_q & ~s2_q;

endmodule

// File: rtl/sc_road_sequencer.sv
// Game-phase sequencer driving the seven row-mux
// selects and the row-register load enable.
module sc_road_sequencer
  import sc_road_sequencer_pkg::*;
#(
  parameter int SELECT_WIDTH    = 2,
  parameter int COUNTDOWN_TICKS = 4,
  parameter int FLASH_TICKS     = 4,
  parameter int SPAWN_PERIOD    = 3
) (
  input  logic                    SC_ROADSEQ_CLOCK_50,
  input  logic                    SC_ROADSEQ_RESET_InHigh,
  input  logic                    SC_ROADSEQ_START_InLow,
  input  logic                    SC_ROADSEQ_PAUSE_InLow,
  input  logic                    SC_ROADSEQ_TICK_InHigh,
  input  logic                    SC_ROADSEQ_CRASH_InHigh,
  output logic [SELECT_WIDTH-1:0] SC_ROADSEQ_SELECT_OUT_1,
  output logic [SELECT_WIDTH-1:0] SC_ROADSEQ_SELECT_OUT_2,
  output logic [SELECT_WIDTH-1:0] SC_ROADSEQ_SELECT_OUT_3,
  output logic [SELECT_WIDTH-1:0] SC_ROADSEQ_SELECT_OUT_4,
  output logic [SELECT_WIDTH-1:0] SC_ROADSEQ_SELECT_OUT_5,
  output logic [SELECT_WIDTH-1:0] SC_ROADSEQ_SELECT_OUT_6,
  output logic [SELECT_WIDTH-1:0] SC_ROADSEQ_SELECT_OUT_7,
  output logic                    SC_ROADSEQ_LOAD_OUT,
  output logic [2:0]              SC_ROADSEQ_STATE_OUT,
  output logic [7:0]              SC_ROADSEQ_SCORE_OUT
);

  localparam logic [2:0] CD_C  = 3'(COUNTDOWN_TICKS);
  localparam logic [2:0] FL_C  = 3'(FLASH_TICKS);
  localparam logic [2:0] SPL_C = 3'(SPAWN_PERIOD - 1);

  logic clk;
  logic rst;
  assign clk = SC_ROADSEQ_CLOCK_50;
  assign rst = SC_ROADSEQ_RESET_InHigh;

  logic start_p;
  logic pause_p;

  sc_button_edge u_start (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (SC_ROADSEQ_START_InLow),
    .press_o (start_p)
  );

  sc_button_edge u_pause (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (SC_ROADSEQ_PAUSE_InLow),
    .press_o (pause_p)
  );

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] g_q, g_d;
  logic [7:0] score_q, score_d;
  rows_t      sel_q, sel_d;
  logic       load_q, load_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      g_q     <= 3'd0;
      score_q <= 8'd0;
      sel_q   <= fill_rows(SEL_ZERO);
      load_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      score_q <= score_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    score_d = score_q;
    sel_d   = sel_q;
    load_d  = 1'b0;
    unique case (state_q)
      IDLE, GAMEOVER: begin
        sel_d  = (state_q == IDLE) ?
                 fill_rows(SEL_ZERO) :
                 fill_rows(SEL_ONES);
        load_d = 1'b1;
        // new game: one clearing load into countdown
        if (start_p) begin
          state_d = COUNTDOWN;
          cnt_d   = 3'd0;
          g_d     = 3'd0;
          score_d = 8'd0;
          sel_d   = fill_rows(SEL_ZERO);
        end
      end
      COUNTDOWN: begin
        if (SC_ROADSEQ_TICK_InHigh) begin
          cnt_d  = cnt_q + 3'd1;
          load_d = 1'b1;
          for (int k = 0; k < ROWS; k++) begin
            sel_d[k] = (3'(k) < cnt_d) ?
                       SEL_ONES : SEL_ZERO;
          end
          if (cnt_d == CD_C) begin
            state_d = PLAY;
          end
        end
      end
      PLAY: begin
        if (SC_ROADSEQ_CRASH_InHigh) begin
          state_d = CRASH;
          cnt_d   = 3'd0;
        end else if (pause_p) begin
          state_d = PAUSE;
        end else if (SC_ROADSEQ_TICK_InHigh) begin
          load_d   = 1'b1;
          sel_d    = fill_rows(SEL_SHIFT);
          sel_d[0] = (g_q == 3'd0) ?
                     SEL_RAND : SEL_ZERO;
          if (g_q == 3'd0) begin
            score_d = sat_inc8(score_q);
          end
          g_d = (g_q == SPL_C) ? 3'd0 : g_q + 3'd1;
        end
      end
      PAUSE: begin
        if (pause_p) begin
          state_d = PLAY;
        end
      end
      CRASH: begin
        if (SC_ROADSEQ_TICK_InHigh) begin
          cnt_d  = cnt_q + 3'd1;
          load_d = 1'b1;
          sel_d  = cnt_d[0] ?
                   fill_rows(SEL_ONES) :
                   fill_rows(SEL_ZERO);
          if (cnt_d == FL_C) begin
            state_d = GAMEOVER;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = fill_rows(SEL_ZERO);
        load_d  = 1'b1;
      end
    endcase
  end

  assign SC_ROADSEQ_SELECT_OUT_1 = SELECT_WIDTH'(sel_q[0]);
  assign SC_ROADSEQ_SELECT_OUT_2 = SELECT_WIDTH'(sel_q[1]);
  assign SC_ROADSEQ_SELECT_OUT_3 = SELECT_WIDTH'(sel_q[2]);
  assign SC_ROADSEQ_SELECT_OUT_4 = SELECT_WIDTH'(sel_q[3]);
  assign SC_ROADSEQ_SELECT_OUT_5 = SELECT_WIDTH'(sel_q[4]);
  assign SC_ROADSEQ_SELECT_OUT_6 = SELECT_WIDTH'(sel_q[5]);
  assign SC_ROADSEQ_SELECT_OUT_7 = SELECT_WIDTH'(sel_q[6]);
  assign SC_ROADSEQ_LOAD_OUT     = load_q;
  assign SC_ROADSEQ_STATE_OUT    = state_q;
  assign SC_ROADSEQ_SCORE_OUT    = score_q;

endmodule

// File: tb/tb_sc_road_sequencer.sv
// Bench for sc_road_sequencer: scripted game walk plus
// random button/tick/crash traffic against a phase model.
module tb_sc_road_sequencer;

  localparam int CD = 4;
  localparam int FL = 4;
  localparam int SP = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  sc_road_sequencer_if #(.SELECT_WIDTH(2)) bus ();

  sc_road_sequencer #(
    .SELECT_WIDTH    (2),
    .COUNTDOWN_TICKS (CD),
    .FLASH_TICKS     (FL),
    .SPAWN_PERIOD    (SP)
  ) dut (
    .SC_ROADSEQ_CLOCK_50     (clk),
    .SC_ROADSEQ_RESET_InHigh (rst),
    .SC_ROADSEQ_START_InLow  (bus.start_n),
    .SC_ROADSEQ_PAUSE_InLow  (bus.pause_n),
    .SC_ROADSEQ_TICK_InHigh  (bus.tick),
    .SC_ROADSEQ_CRASH_InHigh (bus.crash),
    .SC_ROADSEQ_SELECT_OUT_1 (bus.sel[0]),
    .SC_ROADSEQ_SELECT_OUT_2 (bus.sel[1]),
    .SC_ROADSEQ_SELECT_OUT_3 (bus.sel[2]),
    .SC_ROADSEQ_SELECT_OUT_4 (bus.sel[3]),
    .SC_ROADSEQ_SELECT_OUT_5 (bus.sel[4]),
    .SC_ROADSEQ_SELECT_OUT_6 (bus.sel[5]),
    .SC_ROADSEQ_SELECT_OUT_7 (bus.sel[6]),
    .SC_ROADSEQ_LOAD_OUT     (bus.load),
    .SC_ROADSEQ_STATE_OUT    (bus.state),
    .SC_ROADSEQ_SCORE_OUT    (bus.score)
  );

  int n_chk = 0;
  int n_fail = 0;

  // phase model: 0 idle,1 countdown,2 play,3 pause,4 crash,5 over
  int m_st, m_cnt, m_g, m_score, m_load;
  int m_sel [1:7];
  bit sh [3];
  bit ph [3];

  task automatic check_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_g = 0;
    m_score = 0; m_load = 1;
    for (int k = 1; k <= 7; k++) m_sel[k] = 0;
    for (int i = 0; i < 3; i++) begin
      sh[i] = 1'b1;
      ph[i] = 1'b1;
    end
  endtask

  task automatic model_new_game();
    m_st = 1; m_cnt = 0; m_g = 0;
    m_score = 0; m_load = 1;
    for (int k = 1; k <= 7; k++) m_sel[k] = 0;
  endtask

  task automatic model_edge(
    input bit s, input bit p,
    input bit t, input bit c
  );
    // a press acts at the 3rd edge after the pin falls
    bit sp, pp;
    sp = !sh[1] && sh[2];
    pp = !ph[1] && ph[2];
    sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = s;
    ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = p;
    m_load = 0;
    case (m_st)
      0, 5: begin
        m_load = 1;
        for (int k = 1; k <= 7; k++)
          m_sel[k] = (m_st == 5) ? 1 : 0;
        if (sp) model_new_game();
      end
      1: if (t) begin
        m_cnt++;
        m_load = 1;
        for (int k = 1; k <= 7; k++)
          m_sel[k] = (k <= m_cnt) ? 1 : 0;
        if (m_cnt == CD) m_st = 2;
      end
      2: begin
        if (c) begin
          m_st = 4; m_cnt = 0;
        end else if (pp) begin
          m_st = 3;
        end else if (t) begin
          m_load = 1;
          m_sel[1] = (m_g == 0) ? 2 : 0;
          for (int k = 2; k <= 7; k++) m_sel[k] = 3;
          if (m_g == 0 && m_score < 255) m_score++;
          m_g = (m_g + 1) % SP;
        end
      end
      3: if (pp) m_st = 2;
      4: if (t) begin
        m_cnt++;
        m_load = 1;
        for (int k = 1; k <= 7; k++) m_sel[k] = m_cnt % 2;
        if (m_cnt == FL) m_st = 5;
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, " state"}, 32'(bus.state), m_st);
    check_eq({tag, " load"}, 32'(bus.load), m_load);
    check_eq({tag, " score"}, 32'(bus.score), m_score);
    for (int k = 0; k < 7; k++)
      check_eq($sformatf("%s sel%0d", tag, k + 1),
               32'(bus.sel[k]), m_sel[k + 1]);
  endtask

  task automatic cycle(
    input bit s, input bit p,
    input bit t, input bit c,
    input string tag
  );
    bus.start_n = s;
    bus.pause_n = p;
    bus.tick    = t;
    bus.crash   = c;
    @(posedge clk);
    model_edge(s, p, t, c);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cycle(1, 1, 1, 0, tag);
      idle(int'($urandom_range(0, 2)), tag);
    end
  endtask

  task automatic press_start(input string tag);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, tag);
    idle(1, tag);
  endtask

  task automatic press_pause(input string tag);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, tag);
  endtask

  initial begin
    bit s_lvl, p_lvl, t, c;
    bus.start_n = 1'b1;
    bus.pause_n = 1'b1;
    bus.tick    = 1'b0;
    bus.crash   = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1 check_outputs("in_reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check_outputs("post_reset");

    press_start("start");
    ticks(CD, "countdown");
    ticks(6, "play");
    ticks(2, "play2");
    press_pause("pause_on");
    ticks(3, "paused");
    press_pause("pause_off");
    ticks(1, "resume");
    cycle(1, 1, 1, 1, "crash_tick");
    idle(2, "crash");
    ticks(FL, "flash");
    idle(3, "gameover");
    press_start("restart");
    ticks(CD, "countdown2");
    ticks(2, "play3");

    // asynchronous reset between clock edges
    #2 rst = 1'b1;
    model_reset();
    #1 check_outputs("async_rst");
    @(posedge clk);
    #1 check_outputs("rst_hold");
    rst = 1'b0;
    idle(2, "after_rst");

    s_lvl = 1'b1;
    p_lvl = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) s_lvl = ~s_lvl;
      if ($urandom_range(0, 5) == 0) p_lvl = ~p_lvl;
      t = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 24) == 0);
      cycle(s_lvl, p_lvl, t, c, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
